// File: rtl/pipe_issue_ctrl.sv
// Instruction issuer for the 4-stage register/ALU pipeline: program RAM, PC stepping,
// RAW-hazard bubbles against in-flight destinations, and a fixed-length drain on HALT.
module pipe_issue_ctrl #(
    parameter int PROG_DEPTH = 64,
    parameter int PC_W       = 6,
    parameter int WB_LAT     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [22:0]     prog_data,
    input  logic            start,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [3:0]      rd,
    output logic [2:0]      func,
    output logic [7:0]      addr,
    output logic            issue_valid,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     stall_cnt
);

    // state  | meaning
    // S_IDLE | waiting for start; program RAM writable
    // S_RUN  | evaluating the instruction at pc each cycle, issuing or bubbling
    // S_DRAIN| bubbles only while the last writebacks land, then done

    localparam logic [2:0] F_RSH  = 3'b100;
    localparam logic [2:0] F_LSH  = 3'b101;
    localparam logic [2:0] F_NOP  = 3'b110;
    localparam logic [2:0] F_HALT = 3'b111;

    // A write landing WB_LAT cycles after issue is visible to an instruction evaluated
    // in that same cycle, so only the last WB_LAT-1 issued destinations can conflict.
    localparam int SB_D = (WB_LAT > 1) ? WB_LAT - 1 : 1;
    localparam int DC_W = $clog2(WB_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [DC_W-1:0] drain_cnt;
    logic [SB_D-1:0] sb_valid;
    logic [3:0]      sb_rd [SB_D];

    logic [22:0]     prog_mem [PROG_DEPTH];
    logic [22:0]     instr;
    logic [2:0]      i_func;
    logic [3:0]      i_rd;
    logic [3:0]      i_rs1;
    logic [3:0]      i_rs2;
    logic [7:0]      i_addr;
    logic            shift_op;
    logic            hazard;
    logic            issue_now;
    logic            sb_load;
    logic            last_pc;

    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    assign instr    = prog_mem[pc];
    assign i_func   = instr[22:20];
    assign i_rd     = instr[19:16];
    assign i_rs1    = instr[15:12];
    assign i_rs2    = instr[11:8];
    assign i_addr   = instr[7:0];
    assign shift_op = (i_func == F_RSH) || (i_func == F_LSH);
    assign last_pc  = (pc == PC_W'(PROG_DEPTH - 1));

    always_comb begin
        hazard = 1'b0;
        if ((WB_LAT > 1) && (i_func != F_NOP)) begin
            for (int i = 0; i < SB_D; i++) begin
                if (sb_valid[i] &&
                    ((sb_rd[i] == i_rs2) || (!shift_op && (sb_rd[i] == i_rs1)))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign issue_now = (state == S_RUN) && (i_func != F_HALT) && !hazard;
    // A NOP carries no real destination, so it never blocks later readers.
    assign sb_load   = issue_now && (i_func != F_NOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            sb_valid    <= '0;
            for (int i = 0; i < SB_D; i++) begin
                sb_rd[i] <= '0;
            end
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            func        <= F_NOP;
            addr        <= '0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pc          <= '0;
            stall_cnt   <= '0;
        end else begin
            done        <= 1'b0;
            issue_valid <= 1'b0;
            func        <= F_NOP;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            addr        <= '0;

            for (int i = SB_D - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            sb_valid[0] <= sb_load;
            sb_rd[0]    <= i_rd;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        pc        <= '0;
                        stall_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_func == F_HALT) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DC_W'(WB_LAT);
                    end else if (hazard) begin
                        if (stall_cnt != 16'hFFFF) begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end else begin
                        issue_valid <= 1'b1;
                        func        <= i_func;
                        rd          <= i_rd;
                        rs1         <= i_rs1;
                        rs2         <= i_rs2;
                        addr        <= i_addr;
                        // Running off the end of the RAM acts as an implicit HALT.
                        if (last_pc) begin
                            state     <= S_DRAIN;
                            drain_cnt <= DC_W'(WB_LAT);
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DC_W'(1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DC_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: table of small programs with hand-derived stall/issue counts,
// an issue-time model feeding an expected-issue queue, and hand sequences for reset corners.
module tb_pipe_issue_ctrl;
    localparam int WB_LAT = 3;
    localparam int DEPTH  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [22:0] prog_data;
    logic        start;
    logic [3:0]  rs1, rs2, rd;
    logic [2:0]  func;
    logic [7:0]  addr;
    logic        issue_valid, busy, done;
    logic [5:0]  pc;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_issue_ctrl #(.PROG_DEPTH(DEPTH), .PC_W(6), .WB_LAT(WB_LAT)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd),
        .func(func), .addr(addr), .issue_valid(issue_valid), .busy(busy),
        .done(done), .pc(pc), .stall_cnt(stall_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          k;
        logic [22:0] ins;
    } exp_t;
    exp_t exp_q[$];

    logic [22:0] image [DEPTH];

    typedef struct {
        string          name;
        logic [3:0][22:0] prog;
        int             n;
        int             exp_stalls;
        int             exp_issues;
        int             exp_gap;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [22:0] mk(input logic [2:0] f, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [7:0] a);
        return {f, d, s1, s2, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Issue-time model: an instruction issues at the first cycle not earlier than its
    // in-order slot and at least WB_LAT cycles after every producer it reads from.
    task automatic predict(output int stalls, output int done_k);
        int          t;
        int          e;
        int          ev [DEPTH];
        bit          prod [DEPTH];
        logic [22:0] ins;
        logic [22:0] pj;
        logic [2:0]  f;
        exp_t        x;
        t      = 0;
        stalls = 0;
        done_k = 0;
        for (int p = 0; p < DEPTH; p++) begin
            ins = image[p];
            f   = ins[22:20];
            if (f == 3'b111) begin
                done_k = t + WB_LAT + 2;
                return;
            end
            e = t;
            if (f != 3'b110) begin
                for (int j = 0; j < p; j++) begin
                    pj = image[j];
                    if (prod[j] && ((pj[19:16] == ins[11:8]) ||
                        (pj[19:16] == ins[15:12] && f != 3'b100 && f != 3'b101))) begin
                        if (ev[j] + WB_LAT > e) e = ev[j] + WB_LAT;
                    end
                end
            end
            stalls += e - t;
            ev[p]   = e;
            prod[p] = (f != 3'b110);
            x.k     = e + 2;
            x.ins   = ins;
            exp_q.push_back(x);
            t = e + 1;
            if (p == DEPTH - 1) done_k = e + WB_LAT + 2;
        end
    endtask

    // k counts negedges after the edge that samples start; an instruction evaluated in
    // cycle e shows on the outputs at k = e + 2.
    task automatic run(input int n_load, input bit poke, input string tag,
                       output int n_issued, output int gap);
        int   stalls_exp, done_k, k, n_done, first_done, k1, k2;
        exp_t x;
        exp_q.delete();
        predict(stalls_exp, done_k);
        for (int i = 1; i < n_load; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 6'(i); prog_data = image[i];
        end
        @(negedge clk);
        prog_we = (n_load > 0); prog_addr = '0; prog_data = image[0]; start = 1'b1;
        @(negedge clk);
        k = 1; n_done = 0; first_done = -1; n_issued = 0; k1 = -1; k2 = -1;
        while (k <= done_k + 2 && k < 2000) begin
            if (poke && k == 5) begin
                prog_we = 1'b1; prog_addr = '0; prog_data = mk(3'b001, 4'hF, 4'hE, 4'hD, 8'hAA);
                start = 1'b1;
            end else begin
                prog_we = 1'b0; start = 1'b0;
            end
            if (issue_valid) begin
                n_issued++;
                if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL %s extra issue: got issue at k=%0d, want none", tag, k);
                end else begin
                    x = exp_q.pop_front();
                    check({tag, " issue cycle"}, k, x.k);
                    check({tag, " issue fields"}, {func, rd, rs1, rs2, addr}, x.ins);
                end
            end
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (k == done_k - 1) check({tag, " busy in drain"}, busy, 1);
            if (k == done_k)     check({tag, " busy at done"}, busy, 0);
            @(negedge clk);
            k++;
        end
        prog_we = 1'b0; start = 1'b0;
        check({tag, " missing issues"}, exp_q.size(), 0);
        check({tag, " done cycle"}, first_done, done_k);
        check({tag, " done pulses"}, n_done, 1);
        check({tag, " stall_cnt model"}, stall_cnt, stalls_exp);
        gap = (k2 > 0) ? k2 - k1 : -1;
    endtask

    logic [22:0] halt;
    int          n_iss, gap, seen, n_done;

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        halt = mk(3'b111, 4'd0, 4'd0, 4'd0, 8'd0);

        vecs[0] = '{"indep", {halt, halt, mk(3'b001,4'd4,4'd5,4'd6,8'h11), mk(3'b000,4'd3,4'd1,4'd2,8'h10)}, 3, 0, 2, 1};
        vecs[1] = '{"raw",   {halt, halt, mk(3'b011,4'd5,4'd3,4'd4,8'h21), mk(3'b000,4'd3,4'd1,4'd2,8'h20)}, 3, 2, 2, 3};
        vecs[2] = '{"shift", {halt, halt, mk(3'b100,4'd6,4'd3,4'd7,8'h31), mk(3'b000,4'd3,4'd1,4'd2,8'h30)}, 3, 0, 2, 1};
        vecs[3] = '{"shrs2", {halt, halt, mk(3'b101,4'd6,4'd1,4'd3,8'h41), mk(3'b000,4'd3,4'd1,4'd2,8'h40)}, 3, 2, 2, 3};
        vecs[4] = '{"dist2", {halt, mk(3'b011,4'd7,4'd8,4'd3,8'h52), mk(3'b001,4'd4,4'd5,4'd6,8'h51), mk(3'b000,4'd3,4'd1,4'd2,8'h50)}, 4, 1, 3, 1};
        vecs[5] = '{"nop",   {halt, halt, mk(3'b110,4'd9,4'd3,4'd3,8'h61), mk(3'b000,4'd3,4'd1,4'd2,8'h60)}, 3, 0, 2, 1};
        vecs[6] = '{"halt0", {halt, halt, halt, halt}, 1, 0, 0, -1};
        vecs[7] = '{"waw",   {halt, halt, mk(3'b001,4'd3,4'd4,4'd5,8'h71), mk(3'b000,4'd3,4'd1,4'd2,8'h70)}, 3, 0, 2, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst issue_valid", issue_valid, 0);
        check("rst rs1/rs2/rd", {rs1, rs2, rd}, 0);
        check("rst func", func, 3'b110);
        check("rst addr", addr, 0);
        check("rst busy/done", {busy, done}, 0);
        check("rst pc", pc, 0);
        check("rst stall_cnt", stall_cnt, 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vecs[v].n; i++) image[i] = vecs[v].prog[i];
            run(vecs[v].n, 1'b0, vecs[v].name, n_iss, gap);
            check({vecs[v].name, " issues"}, n_iss, vecs[v].exp_issues);
            check({vecs[v].name, " stall_cnt"}, stall_cnt, vecs[v].exp_stalls);
            if (vecs[v].exp_issues >= 2) check({vecs[v].name, " gap"}, gap, vecs[v].exp_gap);
        end

        // Full RAM, no HALT; a write and a start arrive mid-run and must be ignored.
        for (int p = 0; p < DEPTH; p++)
            image[p] = mk(3'(p % 6), 4'(8 + p % 8), 4'(p % 8), 4'((p + 3) % 8), 8'(p));
        run(DEPTH, 1'b1, "full", n_iss, gap);
        check("full issues", n_iss, DEPTH);
        check("full stall_cnt", stall_cnt, 0);
        check("full pc end", pc, DEPTH - 1);
        check("full busy end", busy, 0);

        run(0, 1'b0, "rerun", n_iss, gap);
        check("rerun issues", n_iss, DEPTH);

        // Reset in the cycle the second instruction is on the outputs.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            if (issue_valid) seen++;
            if (seen < 2) @(negedge clk);
        end
        check("midrst second issue", seen, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst issue_valid", issue_valid, 0);
        check("midrst func", func, 3'b110);
        check("midrst pc", pc, 0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy || issue_valid) n_done++;
            @(negedge clk);
        end
        check("midrst quiet after", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
